// File: rtl/mips32_mem_responder.sv
// Shared instruction/data word memory for the pipelined MIPS32 core: fixed-priority arbiter
// (data port wins), one transaction in flight, WAIT_CYC programmable wait states before access.
module mips32_mem_responder #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int WAIT_CYC = 2
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  logic [DATA_W-1:0] mem [2**ADDR_W];

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              dsel_q, dsel_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              if_gnt_q, if_gnt_d;
  logic              d_gnt_q, d_gnt_d;
  logic              if_rvalid_q, if_rvalid_d;
  logic              d_rvalid_q, d_rvalid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              mem_we;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dsel_d      = dsel_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    if_gnt_d    = 1'b0;
    d_gnt_d     = 1'b0;
    if_rvalid_d = 1'b0;
    d_rvalid_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    mem_we      = 1'b0;
    case (state_q)
      IDLE: begin
        if (d_req) begin
          dsel_d  = 1'b1;
          we_d    = d_we;
          addr_d  = d_addr;
          wdata_d = d_wdata;
          d_gnt_d = 1'b1;
          cnt_d   = 4'(WAIT_CYC);
          state_d = BUSY;
        end else if (if_req) begin
          dsel_d   = 1'b0;
          we_d     = 1'b0;
          addr_d   = if_addr;
          if_gnt_d = 1'b1;
          cnt_d    = 4'(WAIT_CYC);
          state_d  = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = RESP;
          if (dsel_q) begin
            d_rvalid_d = 1'b1;
            if (we_q) begin
              mem_we    = 1'b1;
              d_rdata_d = '0;
            end else begin
              d_rdata_d = mem[addr_q];
            end
          end else begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = mem[addr_q];
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dsel_q      <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      if_gnt_q    <= 1'b0;
      d_gnt_q     <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dsel_q      <= dsel_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      if_gnt_q    <= if_gnt_d;
      d_gnt_q     <= d_gnt_d;
      if_rvalid_q <= if_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  // Gated by rst so a store caught by reset on its access edge is dropped along with its ack.
  always_ff @(posedge clk1) begin
    if (mem_we && !rst) mem[addr_q] <= wdata_q;
  end

  assign if_gnt    = if_gnt_q;
  assign d_gnt     = d_gnt_q;
  assign if_rvalid = if_rvalid_q;
  assign d_rvalid  = d_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule
